fifo_frame_serializer: RTL and testbench

- Drains 32-bit words from the single-clock synchronous FIFO in the bridge datapath and emits them as framed bytes on a valid/ready byte stream toward the host link.
- Sits directly downstream of the FIFO: drives its read strobe, consumes its registered read data and uses its fill count.
- Frame format: header byte, count byte, then N words, each word sent MSB byte first.

---
 rtl/fifo_frame_serializer.sv | 219 +++++++++++++++++++++
 tb/tb_fifo_frame_serializer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_serializer.sv
// ---------------------------------------------------------------------------
// fifo_frame_serializer
//
// Drains WIDTH-bit words from the upstream synchronous FIFO and sends them
// to the host link as framed bytes on a valid/ready byte stream.
// Frame: header byte, count byte, then N words, each sent MSB byte first.
//
// Ports:
//   clk_i          clock
//   resetn_i       asynchronous active-low reset
//   fifo_empty_i   FIFO empty flag
//   fifo_filled_i  FIFO occupancy in words
//   fifo_rd_o      FIFO read strobe; fifo_data_i is valid the next cycle
//   fifo_data_i    FIFO read data
//   flush_i        starts a frame of the current contents when below THRESH
//   m_valid_o      byte valid
//   m_data_o       byte
//   m_last_o       final byte of a frame
//   m_ready_i      downstream accept
//   busy_o         high whenever a frame is in progress
//
// Optional feature (macro CHECKSUM_EN):
//   When defined, an 8-bit XOR checksum over the count byte and all payload
//   bytes is appended as the final byte of each frame and carries m_last_o.
// ---------------------------------------------------------------------------
module fifo_frame_serializer #(
  parameter int         WIDTH     = 32,
  parameter int         FILL_W    = 5,
  parameter int         THRESH    = 4,
  parameter int         BURST_MAX = 8,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              fifo_empty_i,
  input  logic [FILL_W-1:0] fifo_filled_i,
  output logic              fifo_rd_o,
  input  logic [WIDTH-1:0]  fifo_data_i,
  input  logic              flush_i,
  output logic              m_valid_o,
  output logic [7:0]        m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o
);

  localparam int              BYTES    = WIDTH / 8;
  localparam int              IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [7:0]      BURST_N  = 8'(BURST_MAX);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    FETCH,
    WAIT,
    SHIFT
`ifdef CHECKSUM_EN
    ,
    CSUM
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    byteIdx_q, byteIdx_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
`ifdef CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                startFrame;
  logic [7:0]          startN;
  logic                lastWordByte;
  logic                finalByte;

  // Start decision and word count latched when leaving IDLE. Occupancy is
  // only looked at here, so writes during a frame cannot change N.
  always_comb begin
    startFrame = (int'(fifo_filled_i) >= THRESH) || (flush_i && !fifo_empty_i);
    if (int'(fifo_filled_i) > BURST_MAX) begin
      startN = BURST_N;
    end else begin
      startN = 8'(fifo_filled_i);
    end
  end

  // State register and datapath registers; everything clears asynchronously
  // so an in-flight frame is abandoned the moment reset is asserted.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      byteIdx_q <= '0;
      shift_q   <= '0;
`ifdef CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      byteIdx_q <= byteIdx_d;
      shift_q   <= shift_d;
`ifdef CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state and output decode. Outputs are a pure function of the
  // registered state, so data/last stay stable while a byte is stalled.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    byteIdx_d    = byteIdx_q;
    shift_d      = shift_q;
`ifdef CHECKSUM_EN
    csum_d       = csum_q;
`endif
    m_valid_o    = 1'b0;
    m_data_o     = 8'h00;
    m_last_o     = 1'b0;
    fifo_rd_o    = 1'b0;
    lastWordByte = (byteIdx_q == LAST_IDX);
    finalByte    = lastWordByte && (cnt_q == 8'd1);

    case (state_q)
      IDLE: begin
        if (startFrame) begin
          cnt_d   = startN;
          state_d = HDR;
        end
      end

      HDR: begin
        m_valid_o = 1'b1;
        m_data_o  = HDR_BYTE;
`ifdef CHECKSUM_EN
        csum_d    = 8'h00;
`endif
        if (m_ready_i) begin
          state_d = CNT;
        end
      end

      CNT: begin
        m_valid_o = 1'b1;
        m_data_o  = cnt_q;
        if (m_ready_i) begin
`ifdef CHECKSUM_EN
          csum_d  = csum_q ^ cnt_q;
`endif
          state_d = FETCH;
        end
      end

      // N never exceeds the occupancy seen in IDLE and nothing else reads
      // the FIFO, so the pop here always finds data.
      FETCH: begin
        fifo_rd_o = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        shift_d   = fifo_data_i;
        byteIdx_d = '0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        m_valid_o = 1'b1;
        m_data_o  = shift_q[WIDTH-1 -: 8];
`ifdef CHECKSUM_EN
        m_last_o  = 1'b0;
`else
        m_last_o  = finalByte;
`endif
        if (m_ready_i) begin
          shift_d   = shift_q << 8;
          byteIdx_d = byteIdx_q + IDX_W'(1);
`ifdef CHECKSUM_EN
          csum_d    = csum_q ^ shift_q[WIDTH-1 -: 8];
`endif
          if (lastWordByte) begin
            cnt_d = cnt_q - 8'd1;
            if (finalByte) begin
`ifdef CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = IDLE;
`endif
            end else begin
              state_d = FETCH;
            end
          end
        end
      end

`ifdef CHECKSUM_EN
      CSUM: begin
        m_valid_o = 1'b1;
        m_data_o  = csum_q;
        m_last_o  = 1'b1;
        if (m_ready_i) begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_fifo_frame_serializer
//
// Self-checking bench for fifo_frame_serializer. A queue stands in for the
// upstream FIFO; expected byte streams are built from the frame rules
// (header, count, words MSB first, optional XOR checksum) and compared with
// every accepted byte. Honours CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fifo_frame_serializer;

  localparam int         WIDTH     = 32;
  localparam int         FILL_W    = 5;
  localparam int         THRESH    = 4;
  localparam int         BURST_MAX = 8;
  localparam int         BYTES     = WIDTH / 8;
  localparam logic [7:0] HDR       = 8'hA5;
`ifdef CHECKSUM_EN
  localparam int         CSUM_ON   = 1;
`else
  localparam int         CSUM_ON   = 0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              fifoEmpty = 1'b1;
  logic [FILL_W-1:0] fifoFilled = '0;
  logic              fifoRd;
  logic [WIDTH-1:0]  fifoData = '0;
  logic              flush = 1'b0;
  logic              mValid;
  logic [7:0]        mData;
  logic              mLast;
  logic              mReady = 1'b1;
  logic              busy;

  int testCount = 0;
  int failCount = 0;

  logic [WIDTH-1:0] fifoQ[$];
  logic [WIDTH-1:0] modelQ[$];
  logic [7:0]       expByte[$];
  logic             expLast[$];

  int         cyc = 0;
  int         rdCount = 0;
  int         xferCount = 0;
  int         validCount = 0;
  int         firstValidCyc = -1;
  int         lastXferCyc = -1;
  int         pushCyc = 0;
  bit         randReady = 1'b0;
  bit         prevStall = 1'b0;
  logic [7:0] prevData = '0;
  logic       prevLast = 1'b0;
  logic [7:0] lastByteSeen = '0;
  logic [WIDTH-1:0] w[4];

  fifo_frame_serializer dut (
    .clk_i         (clk),
    .resetn_i      (resetn),
    .fifo_empty_i  (fifoEmpty),
    .fifo_filled_i (fifoFilled),
    .fifo_rd_o     (fifoRd),
    .fifo_data_i   (fifoData),
    .flush_i       (flush),
    .m_valid_o     (mValid),
    .m_data_o      (mData),
    .m_last_o      (mLast),
    .m_ready_i     (mReady),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic updateFlags();
    fifoFilled = FILL_W'(fifoQ.size());
    fifoEmpty  = (fifoQ.size() == 0);
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] word);
    fifoQ.push_back(word);
    modelQ.push_back(word);
    updateFlags();
  endtask

  // One expected frame of n words taken from the front of the model queue.
  function automatic void addFrame(input int n);
    logic [WIDTH-1:0] word;
    logic [7:0]       b8;
    logic [7:0]       cs;
    cs = 8'(n);
    expByte.push_back(HDR);   expLast.push_back(1'b0);
    expByte.push_back(8'(n)); expLast.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      word = modelQ.pop_front();
      for (int b = 0; b < BYTES; b++) begin
        b8 = 8'(word >> (8 * (BYTES - 1 - b)));
        cs = cs ^ b8;
        expByte.push_back(b8);
        expLast.push_back((CSUM_ON == 0) && (i == n - 1) && (b == BYTES - 1));
      end
    end
    if (CSUM_ON != 0) begin
      expByte.push_back(cs);
      expLast.push_back(1'b1);
    end
  endfunction

  // Frames the design should emit for the current model contents: a flush
  // starts one frame of whatever is present, then frames keep coming while
  // at least THRESH words remain.
  function automatic void planFrames(input bit flushed);
    bit first;
    int n;
    first = flushed;
    while (modelQ.size() >= THRESH || (first && modelQ.size() > 0)) begin
      n = (modelQ.size() > BURST_MAX) ? BURST_MAX : modelQ.size();
      addFrame(n);
      first = 1'b0;
    end
  endfunction

  // Sample on the falling edge, let the rising edge happen, then update the
  // FIFO stand-in and drive new inputs just after it.
  task automatic tick();
    bit         rdSeen;
    logic [7:0] eb;
    logic       el;
    @(negedge clk);
    rdSeen = fifoRd;
    if (fifoRd) rdCount++;
    if (mValid) validCount++;
    if (prevStall) begin
      check("holdValid", 32'(mValid), 32'd1);
      check("holdData", 32'(mData), 32'(prevData));
      check("holdLast", 32'(mLast), 32'(prevLast));
    end
    if (mValid && firstValidCyc < 0) firstValidCyc = cyc;
    if (mValid && mReady) begin
      check("byteExpected", 32'(expByte.size() != 0), 32'd1);
      if (expByte.size() != 0) begin
        eb = expByte.pop_front();
        el = expLast.pop_front();
        check("byteData", 32'(mData), 32'(eb));
        check("byteLast", 32'(mLast), 32'(el));
      end
      xferCount++;
      lastXferCyc  = cyc;
      lastByteSeen = mData;
    end
    prevStall = mValid && !mReady;
    prevData  = mData;
    prevLast  = mLast;
    @(posedge clk);
    cyc++;
    #1;
    if (rdSeen) begin
      fifoData = fifoQ.pop_front();
      updateFlags();
    end
    mReady = randReady ? ($urandom_range(0, 99) >= 30) : 1'b1;
  endtask

  task automatic applyStimulus(input int maxCycles);
    int k;
    k = 0;
    while ((expByte.size() != 0 || busy) && k < maxCycles) begin
      tick();
      k++;
    end
    check("drainTimeout", 32'(k < maxCycles), 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_valid"}, 32'(mValid), 32'd0);
    check({tag, "_data"}, 32'(mData), 32'd0);
    check({tag, "_last"}, 32'(mLast), 32'd0);
    check({tag, "_rd"}, 32'(fifoRd), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    #1 resetn = 1'b0;
    #2 checkOutput("reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    tick();

    // Basic frame with ready held high
    pushWord(32'h11223344);
    pushWord(32'h55667788);
    pushWord(32'h99AABBCC);
    pushWord(32'hDDEEFF00);
    rdCount = 0; xferCount = 0; firstValidCyc = -1; pushCyc = cyc;
    planFrames(1'b0);
    applyStimulus(200);
    check("basicReads", 32'(rdCount), 32'd4);
    check("basicLatency", 32'(firstValidCyc - pushCyc), 32'd1);
    check("basicCycles", 32'(lastXferCyc - firstValidCyc), 32'(1 + 6 * 4 + CSUM_ON));
    check("basicBytes", 32'(xferCount), 32'(2 + 4 * BYTES + CSUM_ON));
    check("basicLastByte", 32'(lastByteSeen), CSUM_ON != 0 ? 32'(8'h04 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88 ^ 8'h99 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD ^ 8'hEE ^ 8'hFF ^ 8'h00) : 32'h00);

    // Burst cap: 12 words become a frame of 8 and then a frame of 4
    rdCount = 0;
    for (int i = 0; i < 12; i++) pushWord($urandom());
    planFrames(1'b0);
    applyStimulus(400);
    check("burstReads", 32'(rdCount), 32'd12);
    check("burstFifoEmpty", 32'(fifoQ.size()), 32'd0);

    // Below threshold: nothing happens until a flush pulse
    pushWord($urandom());
    pushWord($urandom());
    validCount = 0;
    for (int i = 0; i < 5; i++) tick();
    check("belowThreshIdle", 32'(validCount), 32'd0);
    flush = 1'b1;
    planFrames(1'b1);
    tick();
    flush = 1'b0;
    applyStimulus(200);
    check("flushFifoEmpty", 32'(fifoQ.size()), 32'd0);

    // Flush with an empty FIFO never produces a frame
    validCount = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("flushEmptyNoValid", 32'(validCount), 32'd0);
    check("flushEmptyBusy", 32'(busy), 32'd0);

    // Backpressure: random ready on a 1-word and a 3-word frame
    randReady = 1'b1;
    pushWord($urandom());
    flush = 1'b1;
    planFrames(1'b1);
    tick();
    flush = 1'b0;
    applyStimulus(300);
    for (int i = 0; i < 3; i++) pushWord($urandom());
    flush = 1'b1;
    planFrames(1'b1);
    tick();
    flush = 1'b0;
    applyStimulus(400);
    randReady = 1'b0;
    tick();

    // Reset during the third payload byte
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom();
      pushWord(w[i]);
    end
    planFrames(1'b0);
    xferCount = 0;
    for (int g = 0; g < 50 && xferCount < 4; g++) tick();
    check("reachPayload", 32'(xferCount), 32'd4);
    check("midFrameValid", 32'(mValid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rstValidAsync", 32'(mValid), 32'd0);
    check("rstLastAsync", 32'(mLast), 32'd0);
    check("rstBusyAsync", 32'(busy), 32'd0);
    check("rstWordsLeft", 32'(fifoQ.size()), 32'd3);
    expByte.delete();
    expLast.delete();
    modelQ.delete();
    for (int i = 1; i < 4; i++) modelQ.push_back(w[i]);
    @(posedge clk);
    #1 resetn = 1'b1;
    prevStall = 1'b0;
    validCount = 0;
    tick();
    tick();
    check("postRstBusy", 32'(busy), 32'd0);
    check("postRstIdle", 32'(validCount), 32'd0);
    pushWord($urandom());
    planFrames(1'b0);
    applyStimulus(200);
    check("postRstFifoEmpty", 32'(fifoQ.size()), 32'd0);

    // Single word 0x01020304: checksum byte 05 when enabled, else 04 is last
    pushWord(32'h01020304);
    flush = 1'b1;
    planFrames(1'b1);
    tick();
    flush = 1'b0;
    applyStimulus(200);
    check("singleWordLast", 32'(lastByteSeen), CSUM_ON != 0 ? 32'h05 : 32'h04);

    tick();
    check("finalIdle", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
